cuadrado_raiz: RTL and testbench
================================

# cuadrado_raiz

Sequential squarer for the calculator's square-root path: computes R², the inverse of the root unit, with a shift-and-add loop over an unsigned WIDTH-bit root. It sits beside the root unit and reuses its 16-bit result bus format. Optionally it also checks a root against its radicand, reporting the remainder A − R² and whether R² ≤ A. Fixed latency, single start/done handshake.

## Interface

- WIDTH, 8, root width in bits; product and remainder are 2·WIDTH bits (16 at default).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- init  input  1  start request; level sampled only in IDLE.
- R_in  input  WIDTH  unsigned root; sampled on the start edge only.
- A_in  input  2·WIDTH  unsigned radicand; present only with CUADRADO_RESTO_EN.
- PP_out  output  2·WIDTH  R_in², unsigned.
- busy  output  1  high while a computation is in progress (ADD and DONE states).
- done  output  1  one-cycle pulse; PP_out (and RESTO/OK) valid in that cycle.
- RESTO  output  2·WIDTH  A_in − R², two's complement wrap; only with CUADRADO_RESTO_EN.
- OK  output  1  1 when R² ≤ A_in; only with CUADRADO_RESTO_EN.

## Operation

- Reset (rst = 0, any time, asynchronous): state IDLE, counter 0, PP_out 0, busy 0, done 0, RESTO 0, OK 0, internal shift registers 0.
- States: IDLE → ADD → DONE → IDLE.
- IDLE
  - If init = 1 on a clock edge:
    - Load multiplicand register MD = {WIDTH'b0, R_in}.
    - Load multiplier register MR = R_in.
    - Clear PP_out and the counter.
    - Capture A_in (when the feature is enabled).
    - Go to ADD.
  - Otherwise stay in IDLE.
- ADD, one iteration per cycle:
  - If MR[0] = 1, PP_out ← PP_out + MD (2·WIDTH bits). No overflow is possible, since (2^WIDTH − 1)² < 2^(2·WIDTH).
  - MD ← MD << 1; MR ← MR >> 1; counter ← counter + 1.
  - After WIDTH iterations, go to DONE. There is no early exit on MR = 0; latency is fixed.
- DONE:
  - done = 1 for this cycle only; busy = 1.
  - Next edge goes to IDLE.
- init is ignored outside IDLE; it is not queued.
- If init is still high in the first IDLE cycle after DONE, a new computation starts on that edge, giving back-to-back operation with one IDLE cycle between results.
- PP_out holds its result through IDLE until the next start edge clears it.
- R_in and A_in may change freely after the start edge.

## Timing

- Start edge E0 (init = 1 in IDLE).
- Edges E1..EWIDTH perform the iterations.
- The state is DONE during the cycle after edge EWIDTH.
- done is high in exactly one cycle, WIDTH + 1 cycles after E0 (9 cycles at WIDTH = 8).
- busy rises after E0 and falls after the DONE cycle.
- Mid-operation reset clears everything immediately; no done pulse is produced for the aborted operation.

## Configuration

- CUADRADO_RESTO_EN defined:
  - A_in, RESTO and OK ports exist.
  - On the EWIDTH edge, the RESTO and OK registers load the compare of captured A against the final PP value: RESTO = A − PP (2·WIDTH bits, wrap) and OK = no borrow.
  - Both are valid with done and held until the next start edge, which clears them to 0.
- CUADRADO_RESTO_EN undefined:
  - Those three ports and their registers are absent.
  - Behaviour and latency of PP_out, busy and done are unchanged.

## Test plan

- Reset then R_in = 0, init pulse → done exactly 9 cycles after the start edge, PP_out = 0x0000, busy low the following cycle.
- R_in = 255 → PP_out = 0xFE01 (65025). R_in = 1 → 0x0001. R_in = 128 → 0x4000. Sweep all 256 roots against a reference model.
- (CUADRADO_RESTO_EN) R_in = 13, A_in = 180 → PP_out = 169, RESTO = 11, OK = 1. A_in = 169 → RESTO = 0, OK = 1. A_in = 168 → RESTO = 0xFFFF, OK = 0.
- init pulsed again 3 cycles into a run with a different R_in → ignored; first result unaffected; done occurs only once.
- init held high continuously with R_in = 7 → done pulses every 10 cycles, each time with PP_out = 49.
- rst driven low asynchronously 4 cycles into a run with R_in = 200 → all outputs 0 immediately, no done. After release, R_in = 200 → PP_out = 40000 (0x9C40) after 9 cycles.

Source files
------------

// File: rtl/cuadrado_raiz_if.sv
// cuadrado_raiz_if: start/done handshake and result bus of the sequential squarer.
// Optional remainder check (A_in, RESTO, OK) present only when CUADRADO_RESTO_EN is defined.
interface cuadrado_raiz_if #(
    parameter int WIDTH = 8
);
    logic                 init;
    logic [WIDTH-1:0]     R_in;
    logic [2*WIDTH-1:0]   PP_out;
    logic                 busy;
    logic                 done;
`ifdef CUADRADO_RESTO_EN
    logic [2*WIDTH-1:0]   A_in;
    logic [2*WIDTH-1:0]   RESTO;
    logic                 OK;
`endif

`ifdef CUADRADO_RESTO_EN
    modport master (
        output init, R_in, A_in,
        input  PP_out, busy, done, RESTO, OK
    );
    modport slave (
        input  init, R_in, A_in,
        output PP_out, busy, done, RESTO, OK
    );
`else
    modport master (
        output init, R_in,
        input  PP_out, busy, done
    );
    modport slave (
        input  init, R_in,
        output PP_out, busy, done
    );
`endif
endinterface

// File: rtl/cuadrado_raiz.sv
// cuadrado_raiz: sequential shift-and-add squarer, PP_out = R_in * R_in.
// Fixed latency of WIDTH iterations; done pulses WIDTH+1 cycles after the start edge.
// Optional feature macro CUADRADO_RESTO_EN adds the remainder check RESTO = A - R^2, OK = (R^2 <= A).
module cuadrado_raiz #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    cuadrado_raiz_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   md;
    logic [WIDTH-1:0]     mr;
    logic [2*WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0]   pp_sum;
    logic                 start;
    logic                 last_iter;
    logic                 busy_c;
    logic                 done_c;

    // A start is only honoured in IDLE; requests in other states are dropped, not queued.
    assign start     = (state == IDLE) && bus.init;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign pp_sum    = pp + (mr[0] ? md : '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: exactly WIDTH cycles in ADD, no early exit when MR empties.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.init) next_state = ADD;
            ADD:     if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs: busy covers ADD and DONE, done marks the single result cycle.
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            ADD: begin
                busy_c = 1'b1;
            end
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
                done_c = 1'b0;
            end
        endcase
    end

    // Datapath: load operands on start, then one conditional add and shift per ADD cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md    <= '0;
            mr    <= '0;
            pp    <= '0;
            count <= '0;
        end else begin
            if (start) begin
                md    <= {{WIDTH{1'b0}}, bus.R_in};
                mr    <= bus.R_in;
                pp    <= '0;
                count <= '0;
            end else if (state == ADD) begin
                pp    <= pp_sum;
                md    <= md << 1;
                mr    <= mr >> 1;
                count <= count + CW'(1);
            end
        end
    end

    assign bus.PP_out = pp;
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;

`ifdef CUADRADO_RESTO_EN
    logic [2*WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0]   resto_reg;
    logic                 ok_reg;

    // Remainder check: capture A on start, compare against the final product on the last iteration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg     <= '0;
            resto_reg <= '0;
            ok_reg    <= 1'b0;
        end else begin
            if (start) begin
                a_reg     <= bus.A_in;
                resto_reg <= '0;
                ok_reg    <= 1'b0;
            end else if ((state == ADD) && last_iter) begin
                resto_reg <= a_reg - pp_sum;
                ok_reg    <= (pp_sum <= a_reg);
            end
        end
    end

    assign bus.RESTO = resto_reg;
    assign bus.OK    = ok_reg;
`endif

endmodule

// File: tb/tb_cuadrado_raiz.sv
// tb_cuadrado_raiz: directed self-checking bench for cuadrado_raiz.
// Remainder checks are compiled in only when CUADRADO_RESTO_EN is defined.
module tb_cuadrado_raiz;

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    cuadrado_raiz_if #(.WIDTH(8)) bus ();

    cuadrado_raiz #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a root (and radicand) with init high just ahead of the next rising edge.
    task automatic apply_stimulus(input logic [7:0] r, input logic [15:0] a, input logic start);
        @(negedge clk);
        bus.R_in = r;
`ifdef CUADRADO_RESTO_EN
        bus.A_in = a;
`else
        if (a != 16'h0) begin end
`endif
        bus.init = start;
    endtask

    // Start one computation, wait (bounded) for done, check latency, result and the cycle after.
    task automatic run_root(input logic [7:0] r, input logic [15:0] a, input string tag);
        int k;
        logic [15:0] sq;
        sq = 16'(r) * 16'(r);
        apply_stimulus(r, a, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        k = 1;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_output({tag, "_latency"}, 32'(k), 32'd9);
        check_output({tag, "_pp"}, 32'(bus.PP_out), 32'(sq));
`ifdef CUADRADO_RESTO_EN
        check_output({tag, "_resto"}, 32'(bus.RESTO), 32'(a - sq));
        check_output({tag, "_ok"}, 32'(bus.OK), 32'(sq <= a));
`endif
        @(negedge clk);
        check_output({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check_output({tag, "_done_after"}, 32'(bus.done), 32'd0);
        check_output({tag, "_pp_hold"}, 32'(bus.PP_out), 32'(sq));
    endtask

    initial begin
        int   dones;
        int   last_t;
        logic [15:0] sq;
        n_compared   = 0;
        n_mismatched = 0;
        bus.init = 1'b0;
        bus.R_in = '0;
`ifdef CUADRADO_RESTO_EN
        bus.A_in = '0;
`endif

        // Reset state.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_pp", 32'(bus.PP_out), 32'd0);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_done", 32'(bus.done), 32'd0);
`ifdef CUADRADO_RESTO_EN
        check_output("reset_resto", 32'(bus.RESTO), 32'd0);
        check_output("reset_ok", 32'(bus.OK), 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        // Directed roots.
        run_root(8'd0,   16'd0,     "r0");
        run_root(8'd255, 16'hFFFF,  "r255");
        run_root(8'd1,   16'd1,     "r1");
        run_root(8'd128, 16'h4000,  "r128");

        // Remainder corner cases (PP is also checked in the default build).
        run_root(8'd13, 16'd180, "r13_a180");
        run_root(8'd13, 16'd169, "r13_a169");
        run_root(8'd13, 16'd168, "r13_a168");
`ifdef CUADRADO_RESTO_EN
        check_output("r13_a168_resto_ffff", 32'(bus.RESTO), 32'h0000FFFF);
        check_output("r13_a168_ok0", 32'(bus.OK), 32'd0);
`endif

        // Full sweep against the multiply reference model.
        for (int r = 0; r < 256; r++) begin
            run_root(8'(r), 16'h4000, $sformatf("sweep%0d", r));
        end

        // init pulsed mid-run with a different root is ignored.
        apply_stimulus(8'd10, 16'd100, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        repeat (2) @(negedge clk);
        bus.R_in = 8'd3;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        dones = 0;
        last_t = 0;
        for (int t = 5; t <= 24; t++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                last_t = t;
                check_output("ignore_pp", 32'(bus.PP_out), 32'd100);
            end
        end
        check_output("ignore_done_count", 32'(dones), 32'd1);
        check_output("ignore_done_cycle", 32'(last_t), 32'd9);

        // init held high: back-to-back results every 10 cycles.
        apply_stimulus(8'd7, 16'd49, 1'b1);
        dones = 0;
        last_t = -1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (bus.done) begin
                check_output("b2b_pp", 32'(bus.PP_out), 32'd49);
                check_output("b2b_spacing", 32'(t), 32'((last_t < 0) ? 9 : last_t + 10));
                last_t = t;
                dones++;
            end
        end
        bus.init = 1'b0;
        check_output("b2b_done_count", 32'(dones), 32'd4);
        repeat (12) @(negedge clk);

        // Asynchronous reset mid-run aborts with no done.
        apply_stimulus(8'd200, 16'd40000, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        repeat (3) @(negedge clk);
        check_output("abort_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("abort_pp", 32'(bus.PP_out), 32'd0);
        check_output("abort_busy", 32'(bus.busy), 32'd0);
        check_output("abort_done", 32'(bus.done), 32'd0);
`ifdef CUADRADO_RESTO_EN
        check_output("abort_resto", 32'(bus.RESTO), 32'd0);
        check_output("abort_ok", 32'(bus.OK), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check_output("abort_no_done", 32'(dones), 32'd0);
        sq = 16'd40000;
        run_root(8'd200, sq, "r200_after_reset");
        check_output("r200_value", 32'(bus.PP_out), 32'h00009C40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
